// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter: FSM encodings,
// grant-source tags and the saturating increment used by the perf counters.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2,
      ARB_DONE    = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_src_e;

   localparam int PERF_CNT_W = 32;

   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] val);
      return (&val) ? val : val + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating grant/stall statistics for the memory port arbiter; only
// instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf
   import mem_port_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  perf_clr,
   input  logic                  if_grant,
   input  logic                  dm_grant,
   input  logic                  if_stall,
   input  logic                  mem_stall,
   output logic [PERF_CNT_W-1:0] if_grant_cnt,
   output logic [PERF_CNT_W-1:0] dm_grant_cnt,
   output logic [PERF_CNT_W-1:0] if_wait_cnt,
   output logic [PERF_CNT_W-1:0] dm_wait_cnt
);

   always_ff @(posedge clk) begin
      if (!rst || perf_clr) begin
         if_grant_cnt <= '0;
         dm_grant_cnt <= '0;
         if_wait_cnt  <= '0;
         dm_wait_cnt  <= '0;
      end else begin
         if (if_grant)  if_grant_cnt <= sat_inc(if_grant_cnt);
         if (dm_grant)  dm_grant_cnt <= sat_inc(dm_grant_cnt);
         if (if_stall)  if_wait_cnt  <= sat_inc(if_wait_cnt);
         if (mem_stall) dm_wait_cnt  <= sat_inc(dm_wait_cnt);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF and MEM pipeline stages; MEM wins,
// with a bounded IF starvation guard. Define MEM_ARB_PERF_EN for perf counters.
//
// state       | meaning
// ARB_IDLE    | no access in flight, grant decision made here
// ARB_BUSY_IF | fetch access on the memory port, waiting for ram_ready
// ARB_BUSY_DM | load/store access on the memory port, waiting for ram_ready
// ARB_DONE    | one-cycle ack to the granted requester, no new grant
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  dm_ren,
   input  logic                  dm_wen,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_ack,
   output logic                  if_stall,
   output logic                  mem_stall,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   input  logic                  ram_ready
`ifdef MEM_ARB_PERF_EN
   ,
   input  logic                  perf_clr,
   output logic [PERF_CNT_W-1:0] if_grant_cnt,
   output logic [PERF_CNT_W-1:0] dm_grant_cnt,
   output logic [PERF_CNT_W-1:0] if_wait_cnt,
   output logic [PERF_CNT_W-1:0] dm_wait_cnt
`endif
);

   localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   arb_state_e            state;
   arb_state_e            state_nxt;
   gnt_src_e              gnt;
   logic                  grant_if;
   logic                  grant_dm;
   logic                  dm_req;
   logic                  starve_hit;
   logic                  drop;
   logic [STREAK_W-1:0]   streak;
   logic [DATA_WIDTH-1:0] if_hold;
   logic [DATA_WIDTH-1:0] if_rdata_q;

   assign dm_req     = dm_ren | dm_wen;
   assign starve_hit = (STARVE_LIMIT != 0) && if_req && !if_flush && (streak == STREAK_MAX);

   always_ff @(posedge clk) begin
      if (!rst) state <= ARB_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (dm_req && !starve_hit) begin
               grant_dm  = 1'b1;
               state_nxt = ARB_BUSY_DM;
            end else if (if_req && !if_flush) begin
               grant_if  = 1'b1;
               state_nxt = ARB_BUSY_IF;
            end
         end
         ARB_BUSY_IF,
         ARB_BUSY_DM: begin
            if (ram_ready) state_nxt = ARB_DONE;
         end
         ARB_DONE: state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   // Fetch data is parked in if_hold so a flush arriving in DONE can still
   // keep if_rdata at its previous value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt        <= GNT_IF;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         drop       <= 1'b0;
         if_hold    <= '0;
         if_rdata_q <= '0;
         dm_rdata   <= '0;
      end else begin
         if (grant_dm) begin
            gnt      <= GNT_DM;
            ram_addr <= dm_addr;
            ram_din  <= dm_wdata;
            ram_we   <= dm_wen;
            drop     <= 1'b0;
         end else if (grant_if) begin
            gnt      <= GNT_IF;
            ram_addr <= if_addr;
            ram_we   <= 1'b0;
            drop     <= 1'b0;
         end else if (if_flush && gnt == GNT_IF &&
                      (state == ARB_BUSY_IF || state == ARB_DONE)) begin
            drop <= 1'b1;
         end
         if (state == ARB_DONE) ram_we <= 1'b0;
         if (state == ARB_BUSY_IF && ram_ready) if_hold <= ram_dout;
         if (state == ARB_BUSY_DM && ram_ready && !ram_we) dm_rdata <= ram_dout;
         if (if_ack) if_rdata_q <= if_hold;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)                          streak <= '0;
      else if (!if_req || grant_if)      streak <= '0;
      else if (grant_dm && streak != STREAK_MAX) streak <= streak + 1'b1;
   end

   assign ram_cs    = (state == ARB_BUSY_IF) || (state == ARB_BUSY_DM);
   assign if_ack    = (state == ARB_DONE) && (gnt == GNT_IF) && !drop && !if_flush;
   assign dm_ack    = (state == ARB_DONE) && (gnt == GNT_DM);
   assign if_rdata  = if_ack ? if_hold : if_rdata_q;
   assign if_stall  = if_req & ~if_ack;
   assign mem_stall = dm_req & ~dm_ack;

`ifdef MEM_ARB_PERF_EN
   mem_arb_perf u_perf (
      .clk          (clk),
      .rst          (rst),
      .perf_clr     (perf_clr),
      .if_grant     (grant_if),
      .dm_grant     (grant_dm),
      .if_stall     (if_stall),
      .mem_stall    (mem_stall),
      .if_grant_cnt (if_grant_cnt),
      .dm_grant_cnt (dm_grant_cnt),
      .if_wait_cnt  (if_wait_cnt),
      .dm_wait_cnt  (dm_wait_cnt)
   );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default STARVE_LIMIT=4).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_ren, dm_wen;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_ack;
   logic        if_stall, mem_stall;
   logic        ram_cs, ram_we;
   logic [31:0] ram_addr, ram_din, ram_dout;
   logic        ram_ready;
`ifdef MEM_ARB_PERF_EN
   logic        perf_clr;
   logic [31:0] if_grant_cnt, dm_grant_cnt, if_wait_cnt, dm_wait_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .dm_ren    (dm_ren),
      .dm_wen    (dm_wen),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ack    (dm_ack),
      .if_stall  (if_stall),
      .mem_stall (mem_stall),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .ram_ready (ram_ready)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_clr     (perf_clr),
      .if_grant_cnt (if_grant_cnt),
      .dm_grant_cnt (dm_grant_cnt),
      .if_wait_cnt  (if_wait_cnt),
      .dm_wait_cnt  (dm_wait_cnt)
`endif
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
      dm_ren = 1'b0; dm_wen = 1'b0; dm_addr = '0; dm_wdata = '0;
      ram_dout = '0; ram_ready = 1'b0;
`ifdef MEM_ARB_PERF_EN
      perf_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk1 ("rst_cs",     ram_cs,   1'b0);
      chk1 ("rst_we",     ram_we,   1'b0);
      chk32("rst_addr",   ram_addr, 32'h0);
      chk32("rst_din",    ram_din,  32'h0);
      chk1 ("rst_if_ack", if_ack,   1'b0);
      chk1 ("rst_dm_ack", dm_ack,   1'b0);
      chk32("rst_if_rd",  if_rdata, 32'h0);
      chk32("rst_dm_rd",  dm_rdata, 32'h0);
`ifdef MEM_ARB_PERF_EN
      chk32("rst_perf_ig", if_grant_cnt, 32'h0);
      chk32("rst_perf_dw", dm_wait_cnt,  32'h0);
`endif

      // IF only, zero wait: ack two cycles after request
      if_req = 1'b1; if_addr = 32'h100; ram_ready = 1'b1; ram_dout = 32'h20080005;
      #1;
      chk1 ("t1_c0_stall", if_stall, 1'b1);
      chk1 ("t1_c0_cs",    ram_cs,   1'b0);
      next_cycle(); #1;
      chk1 ("t1_c1_cs",    ram_cs,   1'b1);
      chk32("t1_c1_addr",  ram_addr, 32'h100);
      chk1 ("t1_c1_we",    ram_we,   1'b0);
      chk1 ("t1_c1_stall", if_stall, 1'b1);
      chk1 ("t1_c1_ack",   if_ack,   1'b0);
      next_cycle(); #1;
      chk1 ("t1_c2_ack",   if_ack,   1'b1);
      chk32("t1_c2_rd",    if_rdata, 32'h20080005);
      chk1 ("t1_c2_stall", if_stall, 1'b0);
      chk1 ("t1_c2_dmack", dm_ack,   1'b0);
      if_req = 1'b0; ram_ready = 1'b0;
      next_cycle(); #1;
      chk1 ("t1_c3_cs",    ram_cs,   1'b0);
      chk1 ("t1_c3_ack",   if_ack,   1'b0);
      chk32("t1_c3_rd",    if_rdata, 32'h20080005);

      // IF and DM load together: DM first
      if_req = 1'b1; if_addr = 32'h104; dm_ren = 1'b1; dm_addr = 32'h40;
      ram_ready = 1'b1; ram_dout = 32'h11112222;
      next_cycle(); #1;
      chk1 ("t2_dm_cs",   ram_cs,   1'b1);
      chk32("t2_dm_addr", ram_addr, 32'h40);
      chk1 ("t2_dm_we",   ram_we,   1'b0);
      next_cycle(); #1;
      chk1 ("t2_dm_ack",  dm_ack,   1'b1);
      chk1 ("t2_if_nack", if_ack,   1'b0);
      chk32("t2_dm_rd",   dm_rdata, 32'h11112222);
      dm_ren = 1'b0; ram_dout = 32'h33334444;
      next_cycle(); #1;
      chk1 ("t2_idle_cs", ram_cs,   1'b0);
      next_cycle(); #1;
      chk32("t2_if_addr", ram_addr, 32'h104);
      chk1 ("t2_if_we",   ram_we,   1'b0);
      next_cycle(); #1;
      chk1 ("t2_if_ack",  if_ack,   1'b1);
      chk32("t2_if_rd",   if_rdata, 32'h33334444);
      if_req = 1'b0; ram_ready = 1'b0;
      next_cycle();

      // Store with 3 wait states; ren+wen together is a store
      dm_ren = 1'b1; dm_wen = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF;
      ram_dout = 32'h55555555;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if (i == 3) ram_ready = 1'b1;
         #1;
         chk1 ("t3_cs",   ram_cs,    1'b1);
         chk1 ("t3_we",   ram_we,    1'b1);
         chk32("t3_din",  ram_din,   32'hDEADBEEF);
         chk1 ("t3_stall", mem_stall, 1'b1);
      end
      next_cycle(); #1;
      chk1 ("t3_done_cs", ram_cs,    1'b0);
      chk1 ("t3_ack",     dm_ack,    1'b1);
      chk32("t3_rd_keep", dm_rdata,  32'h11112222);
      chk1 ("t3_nstall",  mem_stall, 1'b0);
      dm_ren = 1'b0; dm_wen = 1'b0; ram_ready = 1'b0;
      next_cycle(); #1;
      chk1 ("t3_ack_once", dm_ack,   1'b0);

      // Starvation guard: IF gets every 5th grant while both request
      if_req = 1'b1; if_addr = 32'h200; dm_ren = 1'b1; dm_addr = 32'h300;
      ram_ready = 1'b1; ram_dout = 32'hAAAA0000;
      for (int g = 0; g < 10; g++) begin
         next_cycle(); #1;
         chk1 ("t4_cs", ram_cs, 1'b1);
         chk32("t4_gnt_addr", ram_addr, (g == 4 || g == 9) ? 32'h200 : 32'h300);
         next_cycle(); #1;
         chk1 ("t4_if_ack", if_ack, (g == 4 || g == 9));
         chk1 ("t4_dm_ack", dm_ack, !(g == 4 || g == 9));
         next_cycle();
      end
      if_req = 1'b0; dm_ren = 1'b0; ram_ready = 1'b0;
      next_cycle(); #1;
      chk32("t4_if_rd", if_rdata, 32'hAAAA0000);

      // Flush: none granted while flushing in IDLE, dropped fetch in BUSY_IF
      if_req = 1'b1; if_addr = 32'h500; if_flush = 1'b1;
      #1;
      chk1 ("t5_stall", if_stall, 1'b1);
      next_cycle(); #1;
      chk1 ("t5_nogrant", ram_cs, 1'b0);
      if_flush = 1'b0;
      next_cycle(); #1;
      chk1 ("t5_busy_cs",  ram_cs,   1'b1);
      chk32("t5_busy_addr", ram_addr, 32'h500);
      if_flush = 1'b1;
      next_cycle();
      if_flush = 1'b0; ram_ready = 1'b1; ram_dout = 32'hBBBB0000;
      #1;
      chk1 ("t5_still_busy", ram_cs, 1'b1);
      next_cycle(); #1;
      chk1 ("t5_no_ack",   if_ack,   1'b0);
      chk32("t5_rd_keep",  if_rdata, 32'hAAAA0000);
      chk1 ("t5_stall2",   if_stall, 1'b1);
      chk1 ("t5_done_cs",  ram_cs,   1'b0);
      if_addr = 32'h600; ram_dout = 32'hCCCC0000;
      next_cycle(); #1;
      chk1 ("t5_idle_cs",  ram_cs,   1'b0);
      next_cycle(); #1;
      chk32("t5_new_addr", ram_addr, 32'h600);
      next_cycle(); #1;
      chk1 ("t5_new_ack",  if_ack,   1'b1);
      chk32("t5_new_rd",   if_rdata, 32'hCCCC0000);
      if_req = 1'b0; ram_ready = 1'b0;
      next_cycle();

      // Reset during BUSY_DM with ram_ready low
      dm_ren = 1'b1; dm_addr = 32'h44;
      next_cycle(); #1;
      chk1 ("t6_cs",   ram_cs,   1'b1);
      chk32("t6_addr", ram_addr, 32'h44);
      rst = 1'b0;
      next_cycle(); #1;
      chk1 ("t6_rst_cs",   ram_cs,   1'b0);
      chk1 ("t6_rst_ack",  dm_ack,   1'b0);
      chk32("t6_rst_addr", ram_addr, 32'h0);
      chk32("t6_rst_ifrd", if_rdata, 32'h0);
`ifdef MEM_ARB_PERF_EN
      chk32("t6_perf_dg", dm_grant_cnt, 32'h0);
      chk32("t6_perf_iw", if_wait_cnt,  32'h0);
`endif
      rst = 1'b1; dm_ren = 1'b0;
      next_cycle(); #1;
      chk1 ("t6_idle_cs",  ram_cs, 1'b0);
      chk1 ("t6_idle_ack", dm_ack, 1'b0);
      dm_ren = 1'b1; dm_addr = 32'h48; ram_ready = 1'b1; ram_dout = 32'h12345678;
      next_cycle(); #1;
      chk32("t6_re_addr", ram_addr, 32'h48);
      next_cycle(); #1;
      chk1 ("t6_re_ack",  dm_ack,   1'b1);
      chk32("t6_re_rd",   dm_rdata, 32'h12345678);
      dm_ren = 1'b0; ram_ready = 1'b0;
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline. Grants one requester at a time, sequences the variable-latency memory handshake and returns per-requester acks. Exports stall signals that the pipeline controller folds into if_en/id_en/exe_rst. MEM has priority over IF, with a bounded starvation guard for IF.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width
STARVE_LIMIT, 4, max consecutive MEM grants while IF waits; 0 = strict MEM priority

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
if_req  in  1  fetch request, held high until if_ack
if_addr  in  ADDR_WIDTH  fetch address
if_flush  in  1  branch/jump flush; cancels the pending fetch
if_rdata  out  DATA_WIDTH  fetched instruction, valid while if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
dm_ren  in  1  load request, held until dm_ack
dm_wen  in  1  store request, held until dm_ack
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_rdata  out  DATA_WIDTH  load data, valid while dm_ack=1
dm_ack  out  1  one-cycle data completion pulse
if_stall  out  1  if_req & ~if_ack (combinational)
mem_stall  out  1  (dm_ren|dm_wen) & ~dm_ack (combinational)
ram_cs  out  1  memory access strobe, held until ram_ready
ram_we  out  1  write enable, valid with ram_cs
ram_addr  out  ADDR_WIDTH  registered access address
ram_din  out  DATA_WIDTH  registered write data
ram_dout  in  DATA_WIDTH  memory read data, valid with ram_ready
ram_ready  in  1  access complete; sampled only while ram_cs=1

Behaviour:
- FSM: IDLE, BUSY_IF, BUSY_DM, DONE. Reset → IDLE; ram_cs=0, ram_we=0, ram_addr=0, ram_din=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, streak counter=0.
- IDLE: DM request → BUSY_DM (latch dm_addr/dm_wdata, ram_we=dm_wen). Else IF request with if_flush=0 → BUSY_IF (latch if_addr, ram_we=0). Exception: both requesting and streak==STARVE_LIMIT (STARVE_LIMIT≠0) → BUSY_IF.
- BUSY_*: ram_cs=1; on ram_ready register ram_dout into the granted rdata (loads/fetches only; stores leave dm_rdata unchanged) → DONE.
- DONE: exactly one ack high for one cycle; no new grant in DONE; → IDLE. Minimum request-to-ack latency 2 cycles, throughput one access per 3 cycles at zero wait.
- Streak: +1 on each DM grant while if_req=1; cleared on IF grant or when if_req=0; saturates at STARVE_LIMIT.
- dm_ren & dm_wen both high: treated as store.
- if_flush in IDLE: no fetch granted that cycle. In BUSY_IF or DONE-for-IF: memory access completes, but if_ack is suppressed and if_rdata is not updated (fetch dropped). Any if_flush pulse during the grant sets a sticky drop flag for that grant.
- Request withdrawn mid-BUSY (other than by flush): access still completes and the ack is still issued.
- rst=0 mid-access: FSM → IDLE and ram_cs=0 on the next edge regardless of ram_ready; in-flight access abandoned.

Optional Feature:
MEM_ARB_PERF_EN: when defined, adds 32-bit saturating counters if_grant_cnt, dm_grant_cnt, if_wait_cnt (cycles if_stall=1) and dm_wait_cnt (cycles mem_stall=1), plus input perf_clr (sync clear). All counters are exposed as outputs and reset to 0. When undefined, these ports and counters do not exist and arbitration behaviour is identical.

Decomposition:
- Shared header (alongside the MIPS defines): FSM state encodings ARB_IDLE/ARB_BUSY_IF/ARB_BUSY_DM/ARB_DONE (2-bit) and grant-source constants GNT_IF/GNT_DM.
- One natural sub-module, mem_arb_perf, holding the counters, instantiated only under MEM_ARB_PERF_EN. The arbiter FSM stays in the top module.

Test Plan:
- IF only, if_addr=0x100, ram_ready on the first BUSY cycle, ram_dout=0x20080005 → if_ack at cycle 2, if_rdata=0x20080005, if_stall=1 in cycles 0-1.
- IF and DM load request the same cycle, dm_addr=0x40 → DM served first, dm_ack precedes if_ack, ram_we=0 for both.
- DM store with 3 wait states, dm_wdata=0xDEADBEEF → ram_cs held 4 cycles, ram_we=1, ram_din=0xDEADBEEF, dm_ack once, dm_rdata unchanged.
- STARVE_LIMIT=4, DM requests back-to-back with if_req held → after 4 DM grants the 5th grant goes to IF; the streak then clears.
- if_flush pulsed during BUSY_IF → memory access completes, no if_ack, if_rdata keeps its old value; a new if_req then proceeds normally.
- rst=0 during BUSY_DM with ram_ready low → next cycle ram_cs=0, state IDLE, no ack; with MEM_ARB_PERF_EN, counters read 0.
